// File: rtl/mem_responder.sv
// Single-port word memory responder: latches a request, inserts WAIT_CYCLES wait
// states, performs the access and pulses READY; misaligned/out-of-range accesses set ERR.
module mem_responder #(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic        REQ,
   input  logic        WE,
   input  logic [31:0] ADR,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        READY,
   output logic        BUSY,
   output logic        ERR
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic take, exec;

   logic [31:0] adr_q, wd_q;
   logic        we_q, err_q;

   logic [31:0] mem [DEPTH];

   logic [31:0]           acc_adr, acc_wd;
   logic                  acc_we, acc_err;
   logic [DEPTH_LOG2-1:0] acc_idx;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      take      = 1'b0;
      exec      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (REQ) begin
               take = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt = ST_DONE;
                  exec      = 1'b1;
               end else begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt == 4'd1) begin
               state_nxt = ST_DONE;
               cnt_nxt   = 4'd0;
               exec      = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // With zero wait states the access executes on the sampling edge, so it
   // must see the live inputs rather than the not-yet-loaded latches.
   always_comb begin
      acc_adr = (state == ST_IDLE) ? ADR : adr_q;
      acc_wd  = (state == ST_IDLE) ? WD  : wd_q;
      acc_we  = (state == ST_IDLE) ? WE  : we_q;
      acc_err = (acc_adr[1:0] != 2'b00) || (acc_adr[31:DEPTH_LOG2+2] != '0);
      acc_idx = acc_adr[DEPTH_LOG2+1:2];
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         adr_q <= 32'd0;
         wd_q  <= 32'd0;
         we_q  <= 1'b0;
      end else if (take) begin
         adr_q <= ADR;
         wd_q  <= WD;
         we_q  <= WE;
      end
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         RD    <= 32'd0;
         err_q <= 1'b0;
      end else if (exec) begin
         err_q <= acc_err;
         if (!acc_we) begin
            RD <= acc_err ? 32'd0 : mem[acc_idx];
         end
      end
   end

   // RAM has no reset; an aborted access never reaches exec because the
   // state register is cleared asynchronously.
   always_ff @(posedge CLK) begin
      if (exec && acc_we && !acc_err) begin
         mem[acc_idx] <= acc_wd;
      end
   end

   assign READY = (state == ST_DONE);
   assign BUSY  = (state != ST_IDLE);
   assign ERR   = (state == ST_DONE) && err_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Single-port memory responder for the multicycle core. It answers the shared instruction/data memory requests issued by the control FSM: it captures an address and an optional write word, inserts a programmable number of wait states, then performs the access and returns read data with a one-cycle READY pulse. It sits between the control FSM/datapath address mux and the on-chip word RAM. It also flags misaligned or out-of-range accesses.

## Interface
- DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (256 words)
- WAIT_CYCLES, 2, wait states inserted before each access (0..15)
- CLK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-high
- REQ  in  1  access request; level, sampled only in IDLE
- WE  in  1  1 = write (MemWrite), 0 = read; sampled with REQ
- ADR  in  32  byte address; sampled with REQ
- WD  in  32  write data; sampled with REQ
- RD  out  32  read data, registered; valid while READY=1, held until the next completed read
- READY  out  1  one-cycle pulse: access completed
- BUSY  out  1  1 whenever state is not IDLE
- ERR  out  1  valid with READY: access rejected

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: with REQ=1, the block latches ADR, WE and WD into internal registers.
  - WAIT_CYCLES=0: next state is DONE, and the access executes on this edge.
  - Otherwise: next state is WAIT, with counter = WAIT_CYCLES.
  - With REQ=0, it stays in IDLE.
- WAIT: if counter==1, go to DONE and execute the access on this edge; else decrement the counter.
- DONE: READY=1 for exactly one cycle, then return to IDLE unconditionally.
- REQ is ignored in WAIT and DONE. No back-to-back acceptance: the earliest next sample is the first IDLE cycle.
- Access validity:
  - Error if the latched ADR[1:0] != 0 (misaligned).
  - Error if ADR[31:DEPTH_LOG2+2] != 0 (out of range).
  - Word index is ADR[DEPTH_LOG2+1:2].
- Valid write: RAM[index] <= WD. RD is unchanged. ERR=0.
- Valid read: RD <= RAM[index]. ERR=0.
- Error access: RAM is not modified. On a read, RD <= 0. On a write, RD is unchanged. ERR=1 during DONE.
- ERR is 0 outside DONE.
- Latched WD/ADR are immune to input changes after the sampling edge.
- RAM contents are not reset (undefined after power-up).

## Timing
- Reset values, asynchronous on CLR=1: state=IDLE, counter=0, RD=0, READY=0, BUSY=0, ERR=0, latched ADR/WE/WD=0.
- Reset mid-operation (in WAIT or DONE): the pending access is discarded. A write not yet executed must not reach RAM. Return to IDLE immediately.
- Latency: REQ sampled at edge k → access at edge k+WAIT_CYCLES → READY high in the cycle after edge k+WAIT_CYCLES.
- BUSY rises in the cycle after edge k and falls in the cycle after READY.
- Throughput: one access per WAIT_CYCLES+2 cycles at most.
- Write-then-read of the same word in consecutive requests returns the new data (no forwarding needed; accesses are serialized).
- All outputs are registered or decoded from state only. No combinational path from the REQ/ADR/WD/WE inputs to any output.

## Test plan
- Reset/idle: assert CLR for 3 cycles mid-clock, then release with REQ=0 → RD=0, READY=0, BUSY=0, ERR=0. The outputs respond without waiting for a clock edge.
- Write then read, WAIT_CYCLES=2:
  - Write 0xDEADBEEF to ADR=0x10 with REQ sampled at edge 10 → READY high only between edges 12 and 13, ERR=0.
  - Then read ADR=0x10 → RD=0xDEADBEEF during READY.
- Misaligned write: write 0x12345678 to ADR=0x11 → READY with ERR=1. A subsequent read of 0x10 still returns 0xDEADBEEF.
- Out-of-range read: read ADR=0x400 with DEPTH_LOG2=8 → READY with ERR=1, RD=0.
- Ignored request: hold REQ=1 with ADR=0x20 and WE=1 while BUSY, and toggle ADR/WD during WAIT.
  - Only the originally sampled access executes, once.
  - A new access is sampled at the first IDLE cycle.
- Reset mid-write and zero wait:
  - Start a write of 0xCAFEF00D to 0x20, then pulse CLR in WAIT. A later read of 0x20 must return its prior value.
  - With WAIT_CYCLES=0, a read sampled at edge k gives READY in the cycle after edge k.
